// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//   Single-clock pointer and flag controller for a synchronous FIFO. It sits
//   directly upstream of a dual-port memory whose clocks are both tied to
//   clk_i. It drives the memory's write and read enables and addresses, and it
//   tracks occupancy. From that occupancy it produces the full, empty and
//   almost flags. rvalid_o lines up with the memory's registered read data,
//   which arrives one cycle after the read enable.
//
//   Optional build macro: SYNC_FIFO_CTRL_ERR_FLAG_EN
//     When defined, two sticky error flags are added:
//       ovf_o : a push was attempted while full
//       udf_o : a pop was attempted while empty
//     Only rst_i or flush_i clears them.
//
// Ports
//   clk_i      in   1     clock, rising edge
//   rst_i      in   1     asynchronous active-high reset
//   push_i     in   1     write request (the data goes straight to the memory)
//   pop_i      in   1     read request
//   flush_i    in   1     synchronous clear of all occupancy state
//   wenable_o  out  1     memory write enable (combinational)
//   waddr_o    out  AW    memory write address
//   renable_o  out  1     memory read enable (combinational)
//   raddr_o    out  AW    memory read address
//   rvalid_o   out  1     memory read data is valid this cycle
//   full_o     out  1     count_o == DEPTH
//   empty_o    out  1     count_o == 0
//   afull_o    out  1     count_o >= AFULL_TH
//   aempty_o   out  1     count_o <= AEMPTY_TH
//   count_o    out  AW+1  occupancy, 0..DEPTH
//   ovf_o      out  1     sticky overflow   (macro builds only)
//   udf_o      out  1     sticky underflow  (macro builds only)
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int AW        = 7,
    parameter int DEPTH     = 128,
    parameter int AFULL_TH  = 120,
    parameter int AEMPTY_TH = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic          wenable_o,
    output logic [AW-1:0] waddr_o,
    output logic          renable_o,
    output logic [AW-1:0] raddr_o,
    output logic          rvalid_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          afull_o,
    output logic          aempty_o,
`ifdef SYNC_FIFO_CTRL_ERR_FLAG_EN
    output logic          ovf_o,
    output logic          udf_o,
`endif
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] DEPTH_C     = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_TH_C  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_TH_C = (AW+1)'(AEMPTY_TH);

    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   cnt_r;
    logic          rvalid_r;
    logic          full_r;
    logic          empty_r;
    logic          afull_r;
    logic          aempty_r;

    logic          wr_acc_s;
    logic          rd_acc_s;
    logic [AW-1:0] wptr_nxt_s;
    logic [AW-1:0] rptr_nxt_s;
    logic [AW:0]   cnt_nxt_s;

    // A request is accepted only when the FIFO can take it and no flush is
    // pending. While reset is asserted the enables are gated as well, so the
    // memory cannot be written during reset.
    always_comb begin
        wr_acc_s = push_i & ~full_r  & ~flush_i & ~rst_i;
        rd_acc_s = pop_i  & ~empty_r & ~flush_i & ~rst_i;
    end

    // Next-state values for the pointers and the occupancy counter.
    // A flush has priority over any push or pop.
    always_comb begin
        wptr_nxt_s = wptr_r;
        rptr_nxt_s = rptr_r;
        cnt_nxt_s  = cnt_r;
        if (flush_i) begin
            wptr_nxt_s = {AW{1'b0}};
            rptr_nxt_s = {AW{1'b0}};
            cnt_nxt_s  = {(AW+1){1'b0}};
        end else begin
            if (wr_acc_s) begin
                wptr_nxt_s = wptr_r + AW'(1);
            end else begin
                wptr_nxt_s = wptr_r;
            end
            if (rd_acc_s) begin
                rptr_nxt_s = rptr_r + AW'(1);
            end else begin
                rptr_nxt_s = rptr_r;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   cnt_nxt_s = cnt_r + (AW+1)'(1);
                2'b01:   cnt_nxt_s = cnt_r - (AW+1)'(1);
                default: cnt_nxt_s = cnt_r;
            endcase
        end
    end

    // Occupancy state and read-valid register. The flags are registered
    // decodes of the next count, so they match the registered count_o and
    // have no combinational path from the request inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_r   <= {AW{1'b0}};
            rptr_r   <= {AW{1'b0}};
            cnt_r    <= {(AW+1){1'b0}};
            rvalid_r <= 1'b0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
        end else begin
            wptr_r   <= wptr_nxt_s;
            rptr_r   <= rptr_nxt_s;
            cnt_r    <= cnt_nxt_s;
            rvalid_r <= rd_acc_s;
            full_r   <= (cnt_nxt_s == DEPTH_C);
            empty_r  <= (cnt_nxt_s == {(AW+1){1'b0}});
            afull_r  <= (cnt_nxt_s >= AFULL_TH_C);
            aempty_r <= (cnt_nxt_s <= AEMPTY_TH_C);
        end
    end

`ifdef SYNC_FIFO_CTRL_ERR_FLAG_EN
    logic ovf_r;
    logic udf_r;

    // Sticky error flags. They record any request dropped while the FIFO is
    // full or empty. Only reset or flush clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else if (flush_i) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | (push_i & full_r);
            udf_r <= udf_r | (pop_i & empty_r);
        end
    end

    // Drive the error flag outputs.
    always_comb begin
        ovf_o = ovf_r;
        udf_o = udf_r;
    end
`endif

    // Drive the outputs. The enables are combinational; everything else
    // comes from a register.
    always_comb begin
        wenable_o = wr_acc_s;
        renable_o = rd_acc_s;
        waddr_o   = wptr_r;
        raddr_o   = rptr_r;
        rvalid_o  = rvalid_r;
        full_o    = full_r;
        empty_o   = empty_r;
        afull_o   = afull_r;
        aempty_o  = aempty_r;
        count_o   = cnt_r;
    end

endmodule
